spi_eeprom_sequencer: RTL and testbench

Transaction-level controller that sequences the byte-level SPI master engine to perform complete 25xx-series serial EEPROM accesses: single-byte READ, and single-byte WRITE with write-enable and write-in-progress polling.
- Sits between the AXI-Lite register bank (host side) and the SPI byte engine (engine side).
- Converts one host command into a chain of engine byte transfers and returns one response.

---
 rtl/spi_eeprom_pkg.sv | 71 +++++++
 rtl/spi_eeprom_sequencer_issuer.sv | 74 +++++++
 rtl/spi_eeprom_sequencer.sv | 171 +++++++++++++++++
 tb/tb_spi_eeprom_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_eeprom_pkg.sv
// Shared definitions for the SPI EEPROM sequencer.
// Contents:
//   - 25xx opcodes and the dummy byte.
//   - Phase and FSM state encodings.
//   - The byte-selection helper. It maps (phase, byte index) to the byte to
//     shift out and its chip-enable continuation flag.
package spi_eeprom_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] DUMMY    = 8'hFF;

    typedef enum logic [1:0] {
        PH_CMD  = 2'd0,
        PH_WREN = 2'd1,
        PH_PROG = 2'd2,
        PH_POLL = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_ACK   = 3'd3,
        ST_XFER  = 3'd4,
        ST_GAP   = 3'd5,
        ST_RESP  = 3'd6
    } state_t;

    typedef struct packed {
        logic       cont;
        logic [7:0] data;
    } byte_cmd_t;

    // cont=0 marks the last byte of a chip-enable group.
    function automatic byte_cmd_t select_byte(input phase_t phase, input logic [1:0] idx,
                                              input logic [15:0] addr, input logic [7:0] wdata);
        byte_cmd_t b;
        b = {1'b0, DUMMY};
        case (phase)
            PH_CMD: begin
                case (idx)
                    2'd0:    b = {1'b1, OP_READ};
                    2'd1:    b = {1'b1, addr[15:8]};
                    2'd2:    b = {1'b1, addr[7:0]};
                    default: b = {1'b0, DUMMY};
                endcase
            end
            PH_WREN: b = {1'b0, OP_WREN};
            PH_PROG: begin
                case (idx)
                    2'd0:    b = {1'b1, OP_WRITE};
                    2'd1:    b = {1'b1, addr[15:8]};
                    2'd2:    b = {1'b1, addr[7:0]};
                    default: b = {1'b0, wdata};
                endcase
            end
            PH_POLL: begin
                case (idx)
                    2'd0:    b = {1'b1, OP_RDSR};
                    default: b = {1'b0, DUMMY};
                endcase
            end
            default: b = {1'b0, DUMMY};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_eeprom_sequencer_issuer.sv
// spi_byte_issuer: runs one byte through the SPI engine handshake.
//   go/tx_byte/tx_cont : request from the sequencer (accepted only when idle).
//   eng_*              : byte-engine handshake (start pulse, data, ready).
//   done/rx_byte       : one-cycle completion pulse and the captured byte.
module spi_byte_issuer
    import spi_eeprom_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] tx_byte,
    input  logic       tx_cont,
    input  logic       eng_ready,
    input  logic [7:0] eng_rxData,
    output logic       eng_start,
    output logic       eng_continued,
    output logic [7:0] eng_txData,
    output logic       done,
    output logic [7:0] rx_byte
);

    state_t state_r;

    // Byte handshake FSM. LOAD holds the byte until the engine is idle, so a
    // start pulse is never issued while eng_ready is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            eng_start     <= 1'b0;
            eng_continued <= 1'b0;
            eng_txData    <= 8'h00;
            done          <= 1'b0;
            rx_byte       <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (go) begin
                        eng_txData    <= tx_byte;
                        eng_continued <= tx_cont;
                        state_r       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (eng_ready) begin
                        eng_start <= 1'b1;
                        state_r   <= ST_START;
                    end
                end
                ST_START: begin
                    eng_start <= 1'b0;
                    state_r   <= ST_ACK;
                end
                ST_ACK: begin
                    if (!eng_ready) begin
                        state_r <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (eng_ready) begin
                        rx_byte <= eng_rxData;
                        done    <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    eng_start <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/spi_eeprom_sequencer.sv
// spi_eeprom_sequencer: turns one host READ/WRITE command into the 25xx byte
// chain and returns a single response.
//   cmd_*          : host command handshake (valid/ready, write flag, address, data).
//   rsp_*          : one-cycle response strobe with read data and poll-limit error.
//   eng_*          : SPI byte engine interface, driven through spi_byte_issuer.
// Parameters:
//   POLL_MAX       : maximum RDSR polls per WRITE before reporting an error.
//   CMD_GAP        : idle cycles enforced after each chip-enable-releasing byte.
module spi_eeprom_sequencer
    import spi_eeprom_pkg::*;
#(
    parameter int POLL_MAX = 1024,
    parameter int CMD_GAP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_error,
    output logic        eng_start,
    output logic        eng_continued,
    output logic [7:0]  eng_txData,
    input  logic [7:0]  eng_rxData,
    input  logic        eng_ready
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int GW = (CMD_GAP > 1) ? $clog2(CMD_GAP) : 1;
    localparam logic [PW-1:0] POLL_SAT  = PW'(POLL_MAX);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CMD_GAP - 1);

    state_t          state_r;
    phase_t          phase_r;
    logic [1:0]      idx_r;
    logic [PW-1:0]   poll_r;
    logic [GW-1:0]   gap_r;
    logic [15:0]     addr_r;
    logic [7:0]      wdata_r;
    logic            go_r;
    byte_cmd_t       cur_s;
    logic            done_s;
    logic [7:0]      rx_s;

    // Byte and continuation flag for the current phase/index.
    always_comb begin
        cur_s = select_byte(phase_r, idx_r, addr_r, wdata_r);
    end

    // Transaction FSM: phase ordering, byte index, gap timing and polling.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            phase_r   <= PH_CMD;
            idx_r     <= 2'd0;
            poll_r    <= '0;
            gap_r     <= '0;
            addr_r    <= 16'h0000;
            wdata_r   <= 8'h00;
            go_r      <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_error <= 1'b0;
        end else begin
            go_r      <= 1'b0;
            rsp_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr_r    <= cmd_addr;
                        wdata_r   <= cmd_wdata;
                        phase_r   <= cmd_write ? PH_WREN : PH_CMD;
                        idx_r     <= 2'd0;
                        poll_r    <= '0;
                        go_r      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state_r   <= ST_LOAD;
                    end else begin
                        cmd_ready <= eng_ready;
                    end
                end
                // Waiting for the issuer to finish the current byte.
                ST_LOAD: begin
                    if (done_s) begin
                        if (cur_s.cont) begin
                            idx_r <= idx_r + 2'd1;
                            go_r  <= 1'b1;
                        end else begin
                            idx_r <= 2'd0;
                            gap_r <= '0;
                            case (phase_r)
                                PH_CMD: begin
                                    rsp_valid <= 1'b1;
                                    rsp_rdata <= rx_s;
                                    rsp_error <= 1'b0;
                                    state_r   <= ST_RESP;
                                end
                                PH_WREN: begin
                                    phase_r <= PH_PROG;
                                    state_r <= ST_GAP;
                                end
                                PH_PROG: begin
                                    phase_r <= PH_POLL;
                                    state_r <= ST_GAP;
                                end
                                PH_POLL: begin
                                    if (poll_r != POLL_SAT) begin
                                        poll_r <= poll_r + PW'(1);
                                    end
                                    if (!rx_s[0]) begin
                                        rsp_valid <= 1'b1;
                                        rsp_rdata <= 8'h00;
                                        rsp_error <= 1'b0;
                                        state_r   <= ST_RESP;
                                    end else if (poll_r >= POLL_LAST) begin
                                        // This was poll number POLL_MAX and WIP is still set.
                                        rsp_valid <= 1'b1;
                                        rsp_rdata <= 8'h00;
                                        rsp_error <= 1'b1;
                                        state_r   <= ST_RESP;
                                    end else begin
                                        state_r <= ST_GAP;
                                    end
                                end
                                default: state_r <= ST_IDLE;
                            endcase
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_r == GAP_LAST) begin
                        go_r    <= 1'b1;
                        state_r <= ST_LOAD;
                    end else begin
                        gap_r <= gap_r + GW'(1);
                    end
                end
                ST_RESP: begin
                    cmd_ready <= eng_ready;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    cmd_ready <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    spi_byte_issuer u_issuer (
        .clk           (clk),
        .rst           (rst),
        .go            (go_r),
        .tx_byte       (cur_s.data),
        .tx_cont       (cur_s.cont),
        .eng_ready     (eng_ready),
        .eng_rxData    (eng_rxData),
        .eng_start     (eng_start),
        .eng_continued (eng_continued),
        .eng_txData    (eng_txData),
        .done          (done_s),
        .rx_byte       (rx_s)
    );

endmodule

// File: tb/tb_spi_eeprom_sequencer.sv
// Directed testbench for spi_eeprom_sequencer with a behavioural SPI byte
// engine and a canned 25xx EEPROM reply model.
module tb_spi_eeprom_sequencer;

    localparam int POLL_MAX = 8;
    localparam int CMD_GAP  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = 16'h0000;
    logic [7:0]  cmd_wdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_error;
    logic        eng_start;
    logic        eng_continued;
    logic [7:0]  eng_txData;
    logic [7:0]  eng_rxData;
    logic        eng_ready;

    // Bench knobs (written only by the stimulus process).
    int         fall_delay = 0;
    logic [7:0] rd_val     = 8'h00;
    int         busy_polls = 0;
    logic       wip_stuck  = 1'b0;

    // Engine model state and logs (written only by the model processes).
    logic [8:0] tx_log[$];
    int         gap_log[$];
    int         n_starts = 0;
    int         n_bad_starts = 0;
    int         n_rsp = 0;
    int         cyc = 0;
    int         e_st = 0;
    int         e_cnt = 0;
    int         poll_n = 0;
    int         ce_high_cyc = 0;
    logic       ce_is_high = 1'b1;
    logic [7:0] e_tx = 8'h00;
    logic [7:0] grp_op = 8'h00;
    logic       e_cont = 1'b0;

    // Scoreboard
    int         n_tests = 0;
    int         n_fail = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    spi_eeprom_sequencer #(.POLL_MAX(POLL_MAX), .CMD_GAP(CMD_GAP)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_error     (rsp_error),
        .eng_start     (eng_start),
        .eng_continued (eng_continued),
        .eng_txData    (eng_txData),
        .eng_rxData    (eng_rxData),
        .eng_ready     (eng_ready)
    );

    // Engine model: logs each started byte, drops ready after fall_delay,
    // stays busy three cycles, then returns the EEPROM reply.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            eng_ready  <= 1'b1;
            eng_rxData <= 8'h00;
            e_st       <= 0;
            e_cnt      <= 0;
            ce_is_high <= 1'b1;
        end else begin
            if (eng_start) begin
                n_starts <= n_starts + 1;
                if (e_st != 0 || !eng_ready) n_bad_starts <= n_bad_starts + 1;
            end
            case (e_st)
                0: begin
                    if (eng_start) begin
                        tx_log.push_back({eng_continued, eng_txData});
                        if (ce_is_high) begin
                            gap_log.push_back(cyc - ce_high_cyc);
                            grp_op <= eng_txData;
                        end
                        if (eng_txData == 8'h06) poll_n <= 0;
                        ce_is_high <= 1'b0;
                        e_tx       <= eng_txData;
                        e_cont     <= eng_continued;
                        e_cnt      <= fall_delay;
                        e_st       <= 1;
                    end
                end
                1: begin
                    if (e_cnt == 0) begin
                        eng_ready <= 1'b0;
                        e_cnt     <= 2;
                        e_st      <= 2;
                    end else begin
                        e_cnt <= e_cnt - 1;
                    end
                end
                2: begin
                    if (e_cnt == 0) begin
                        eng_ready <= 1'b1;
                        if (e_tx == 8'hFF && grp_op == 8'h05) begin
                            eng_rxData <= (wip_stuck || poll_n < busy_polls) ? 8'h01 : 8'h00;
                            poll_n     <= poll_n + 1;
                        end else if (e_tx == 8'hFF) begin
                            eng_rxData <= rd_val;
                        end else begin
                            eng_rxData <= 8'h00;
                        end
                        if (!e_cont) begin
                            ce_is_high  <= 1'b1;
                            ce_high_cyc <= cyc;
                        end
                        e_st <= 0;
                    end else begin
                        e_cnt <= e_cnt - 1;
                    end
                end
                default: e_st <= 0;
            endcase
        end
    end

    // Response strobe counter.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) n_rsp <= n_rsp + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic exp_add(input logic [8:0] v);
        exp_q.push_back(v);
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d, input logic keep);
        int n;
        n = 0;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("accept_wait", 32'(n < 200), 32'd1);
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
        check_val("ready_drop", 32'(cmd_ready), 32'd0);
    endtask

    task automatic wait_rsp(input string tag, output logic [7:0] rdata, output logic err);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val($sformatf("%s_rsp_seen", tag), 32'(n < 3000), 32'd1);
        rdata = rsp_rdata;
        err   = rsp_error;
        check_val($sformatf("%s_ready_in_resp", tag), 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check_val($sformatf("%s_rsp_one_cycle", tag), 32'(rsp_valid), 32'd0);
        check_val($sformatf("%s_rdata_hold", tag), 32'(rsp_rdata), 32'(rdata));
        check_val($sformatf("%s_ready_after", tag), 32'(cmd_ready), 32'd1);
    endtask

    task automatic check_seq(input string tag, input int base);
        check_val($sformatf("%s_nbytes", tag), 32'(tx_log.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < tx_log.size(); i++)
            check_val($sformatf("%s_byte%0d", tag, i), 32'(tx_log[base + i]), 32'(exp_q[i]));
    endtask

    task automatic read_seq(input logic [15:0] a);
        exp_q.delete();
        exp_add({1'b1, 8'h03});
        exp_add({1'b1, a[15:8]});
        exp_add({1'b1, a[7:0]});
        exp_add({1'b0, 8'hFF});
    endtask

    task automatic write_seq(input logic [15:0] a, input logic [7:0] d, input int polls);
        exp_q.delete();
        exp_add({1'b0, 8'h06});
        exp_add({1'b1, 8'h02});
        exp_add({1'b1, a[15:8]});
        exp_add({1'b1, a[7:0]});
        exp_add({1'b0, d});
        for (int i = 0; i < polls; i++) begin
            exp_add({1'b1, 8'h05});
            exp_add({1'b0, 8'hFF});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        logic       er;
        int         b;
        int         b2;
        int         g;
        int         s0;
        int         bad0;
        int         r0;
        int         n;
        int         cnt;
        logic       gap_ok;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check_val("rst_rsp_error", 32'(rsp_error), 32'd0);
        check_val("rst_eng_start", 32'(eng_start), 32'd0);
        check_val("rst_eng_cont", 32'(eng_continued), 32'd0);
        check_val("rst_eng_tx", 32'(eng_txData), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_ready", 32'(cmd_ready), 32'd1);

        // READ 0x1234 -> A5
        rd_val = 8'hA5;
        b = tx_log.size();
        issue(1'b0, 16'h1234, 8'h00, 1'b0);
        wait_rsp("read1", rd, er);
        check_val("read1_rdata", 32'(rd), 32'h0000_00A5);
        check_val("read1_err", 32'(er), 32'd0);
        read_seq(16'h1234);
        check_seq("read1", b);

        // WRITE 0x00FF=0x5A, status 01,01,00
        busy_polls = 2;
        b = tx_log.size();
        g = gap_log.size();
        issue(1'b1, 16'h00FF, 8'h5A, 1'b0);
        wait_rsp("write1", rd, er);
        check_val("write1_rdata", 32'(rd), 32'd0);
        check_val("write1_err", 32'(er), 32'd0);
        write_seq(16'h00FF, 8'h5A, 3);
        check_seq("write1", b);
        check_val("write1_ngaps", 32'(gap_log.size() - g), 32'd5);
        gap_ok = 1'b1;
        for (int i = g; i < gap_log.size(); i++)
            if (gap_log[i] < CMD_GAP) gap_ok = 1'b0;
        check_val("write1_gap_min", 32'(gap_ok), 32'd1);

        // WRITE with WIP stuck: exactly POLL_MAX polls then error
        wip_stuck = 1'b1;
        b = tx_log.size();
        issue(1'b1, 16'h0ABC, 8'h33, 1'b0);
        wait_rsp("stuck", rd, er);
        check_val("stuck_err", 32'(er), 32'd1);
        check_val("stuck_rdata", 32'(rd), 32'd0);
        cnt = 0;
        for (int i = b; i < tx_log.size(); i++)
            if (tx_log[i] == 9'h105) cnt++;
        check_val("stuck_rdsr_count", 32'(cnt), 32'(POLL_MAX));
        write_seq(16'h0ABC, 8'h33, POLL_MAX);
        check_seq("stuck", b);
        wip_stuck = 1'b0;

        // cmd_valid held with changing address during a READ
        rd_val = 8'h3C;
        r0 = n_rsp;
        b = tx_log.size();
        issue(1'b0, 16'h0100, 8'h00, 1'b1);
        cmd_addr = 16'h0200;
        wait_rsp("held1", rd, er);
        check_val("held1_rdata", 32'(rd), 32'h0000_003C);
        read_seq(16'h0100);
        check_seq("held1", b);
        b2 = tx_log.size();
        rd_val = 8'hC3;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_val("held_second_accept", 32'(cmd_ready), 32'd0);
        wait_rsp("held2", rd, er);
        check_val("held2_rdata", 32'(rd), 32'h0000_00C3);
        read_seq(16'h0200);
        check_seq("held2", b2);
        check_val("held_rsp_count", 32'(n_rsp - r0), 32'd2);

        // Reset during PROG phase
        busy_polls = 0;
        b = tx_log.size();
        issue(1'b1, 16'h4321, 8'hEE, 1'b0);
        n = 0;
        while (tx_log.size() < b + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("prog_reached", 32'(n < 500), 32'd1);
        r0 = n_rsp;
        rst = 1'b0;
        @(negedge clk);
        check_val("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        check_val("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("abort_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check_val("abort_rsp_error", 32'(rsp_error), 32'd0);
        check_val("abort_eng_start", 32'(eng_start), 32'd0);
        check_val("abort_eng_cont", 32'(eng_continued), 32'd0);
        check_val("abort_eng_tx", 32'(eng_txData), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check_val("abort_no_rsp", 32'(n_rsp - r0), 32'd0);
        rd_val = 8'h99;
        b = tx_log.size();
        issue(1'b0, 16'h0042, 8'h00, 1'b0);
        wait_rsp("post_rst", rd, er);
        check_val("post_rst_rdata", 32'(rd), 32'h0000_0099);
        read_seq(16'h0042);
        check_seq("post_rst", b);

        // Engine delays its ready fall by 3 cycles
        fall_delay = 3;
        rd_val = 8'h5C;
        s0 = n_starts;
        bad0 = n_bad_starts;
        b = tx_log.size();
        issue(1'b0, 16'h7E81, 8'h00, 1'b0);
        wait_rsp("slow_read", rd, er);
        check_val("slow_read_rdata", 32'(rd), 32'h0000_005C);
        read_seq(16'h7E81);
        check_seq("slow_read", b);
        check_val("slow_read_starts", 32'(n_starts - s0), 32'd4);
        busy_polls = 1;
        s0 = n_starts;
        b = tx_log.size();
        issue(1'b1, 16'hBEEF, 8'hC7, 1'b0);
        wait_rsp("slow_write", rd, er);
        check_val("slow_write_err", 32'(er), 32'd0);
        write_seq(16'hBEEF, 8'hC7, 2);
        check_seq("slow_write", b);
        check_val("slow_write_starts", 32'(n_starts - s0), 32'd9);
        check_val("slow_bad_starts", 32'(n_bad_starts - bad0), 32'd0);
        check_val("total_bad_starts", 32'(n_bad_starts), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
